// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles the pipeline request/response channel and the data-memory port
//   of mem_access_unit.
//   slave  : view taken by mem_access_unit (consumes requests, drives memory)
//   master : view taken by the environment (pipeline + memory model)
//   Request : req_valid, req_write, funct3[2:0], req_addr[63:0], req_wdata[63:0], req_ready
//   Response: resp_valid, resp_rdata[63:0], resp_fault
//   Memory  : mem_read, mem_write, mem_address[63:0], mem_write_data[63:0], mem_read_data[63:0]
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage initiator for a doubleword-wide data memory. Accepts RISC-V
//   loads/stores with byte addresses, extracts and extends load lanes,
//   performs read-modify-write for B/H/W stores and flags misaligned,
//   out-of-range or illegal accesses.
//   Ports:
//     clk   : single clock, posedge
//     reset : asynchronous, active-high
//     bus   : mem_access_unit_if.slave (request, response and memory port)
module mem_access_unit #(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;
  logic [63:0] merge_q, merge_d;
  logic [63:0] idx_q, idx_d;

  logic [2:0]  off;
  logic [63:0] idx;
  logic        illegal, misaligned, out_of_range, fault, partial;
  logic [63:0] lane, load_ext;
  logic [7:0]  byte_en;
  logic [63:0] lane_mask, wdata_sh, merged;

  assign off = bus.req_addr[2:0];
  assign idx = {3'b000, bus.req_addr[63:3]};

  // Access decode: legality, alignment and range.
  always_comb begin
    illegal      = (bus.funct3 == 3'b111) || (bus.req_write && bus.funct3[2]);
    out_of_range = (idx >= 64'(MEM_DEPTH));
    case (bus.funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off[1:0] != 2'b00);
      2'b11:   misaligned = (off != 3'b000);
      default: misaligned = 1'b0;
    endcase
    fault   = illegal || misaligned || out_of_range;
    partial = bus.req_write && (bus.funct3[1:0] != 2'b11);
  end

  // Load lane select and extension.
  always_comb begin
    lane = bus.mem_read_data >> {off, 3'b000};
    case (bus.funct3)
      3'b000:  load_ext = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {56'd0, lane[7:0]};
      3'b101:  load_ext = {48'd0, lane[15:0]};
      3'b110:  load_ext = {32'd0, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // Byte-lane merge of store data into the old doubleword.
  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   byte_en = 8'h01;
      2'b01:   byte_en = 8'h03;
      2'b10:   byte_en = 8'h0F;
      default: byte_en = 8'hFF;
    endcase
    byte_en   = byte_en << off;
    lane_mask = '0;
    for (int unsigned i = 0; i < 8; i++)
      lane_mask[i*8 +: 8] = {8{byte_en[i]}};
    wdata_sh = bus.req_wdata << {off, 3'b000};
    merged   = (bus.mem_read_data & ~lane_mask) | (wdata_sh & lane_mask);
  end

  always_comb begin
    state_d            = state_q;
    resp_valid_d       = 1'b0;
    resp_rdata_d       = '0;
    resp_fault_d       = 1'b0;
    merge_d            = merge_q;
    idx_d              = idx_q;
    bus.req_ready      = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = idx;
    bus.mem_write_data = bus.req_wdata;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (!bus.req_write) begin
            bus.mem_read = 1'b1;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
          end else if (!partial) begin
            bus.mem_write = 1'b1;
            resp_valid_d  = 1'b1;
          end else begin
            bus.mem_read = 1'b1;
            merge_d      = merged;
            idx_d        = idx;
            state_d      = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        bus.mem_write      = 1'b1;
        bus.mem_address    = idx_q;
        bus.mem_write_data = merge_q;
        resp_valid_d       = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes must be quiet while reset is held, even though the request
    // path is otherwise combinational from the pipeline.
    if (reset) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      merge_q      <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      merge_q      <= merge_d;
      idx_q        <= idx_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [2:0] F_B  = 3'b000, F_H  = 3'b001, F_W  = 3'b010, F_D = 3'b011;
  localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_WU = 3'b110, F_X = 3'b111;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [63:0] mem [256];

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data memory: combinational read, posedge write.
  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[7:0]] : 64'd0;
  always @(posedge clk)
    if (bus.mem_write) mem[bus.mem_address[7:0]] <= bus.mem_write_data;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at the negedge so it is stable for the next posedge.
  task automatic start(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.funct3    = f3;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic f, input logic [63:0] d);
    chk({tag, ".valid"}, 64'(bus.resp_valid), 64'(v));
    chk({tag, ".fault"}, 64'(bus.resp_fault), 64'(f));
    chk({tag, ".rdata"}, bus.resp_rdata, d);
  endtask

  task automatic chk_strobes(input string tag, input logic r, input logic w);
    chk({tag, ".mem_read"},  64'(bus.mem_read),  64'(r));
    chk({tag, ".mem_write"}, 64'(bus.mem_write), 64'(w));
  endtask

  task automatic store_d(input logic [63:0] a, input logic [63:0] d);
    start(1'b1, F_D, a, d);
    chk_strobes("sd_acc", 1'b0, 1'b1);
    chk("sd_acc.addr", bus.mem_address, a >> 3);
    chk("sd_acc.wdata", bus.mem_write_data, d);
    next();
    chk_resp("sd_resp", 1'b1, 1'b0, 64'd0);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] exp);
    start(1'b0, f3, a, 64'd0);
    chk_strobes({tag, "_acc"}, 1'b1, 1'b0);
    next();
    chk_resp(tag, 1'b1, 1'b0, exp);
  endtask

  task automatic faulty(input string tag, input logic w, input logic [2:0] f3, input logic [63:0] a);
    start(w, f3, a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_strobes({tag, "_acc"}, 1'b0, 1'b0);
    next();
    chk_resp(tag, 1'b1, 1'b1, 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.funct3    = F_D;
    bus.req_addr  = 64'd96;
    bus.req_wdata = '0;
    #2;
    chk_resp("reset", 1'b0, 1'b0, 64'd0);
    chk_strobes("reset", 1'b0, 1'b0);
    chk("reset.ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_strobes("idle", 1'b0, 1'b0);

    // Preload through the DUT's own SD path.
    store_d(64'd96,   64'h0000_0000_0000_000D);
    store_d(64'd32,   64'h0000_0000_0000_8080);
    store_d(64'd40,   64'h1122_3344_5566_7788);
    store_d(64'd8,    64'h0123_4567_89AB_CDEF);
    store_d(64'd2040, 64'h0000_0000_0000_CAFE);

    // LD at 96 -> index 12
    start(1'b0, F_D, 64'd96, 64'd0);
    chk("ld96.addr", bus.mem_address, 64'd12);
    chk_strobes("ld96_acc", 1'b1, 1'b0);
    next();
    chk_resp("ld96", 1'b1, 1'b0, 64'd13);
    @(posedge clk); #1;
    chk("ld96.pulse", 64'(bus.resp_valid), 64'd0);

    // Back-to-back loads on word 4 (valid held across cycles)
    start(1'b0, F_B, 64'd32, 64'd0);
    @(posedge clk); #1;
    chk_resp("lb32", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    start(1'b0, F_BU, 64'd32, 64'd0);
    @(posedge clk); #1;
    chk_resp("lbu32", 1'b1, 1'b0, 64'h0000_0000_0000_0080);
    start(1'b0, F_H, 64'd32, 64'd0);
    next();
    chk_resp("lh32", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_8080);

    load("lw44",   F_W,  64'd44,   64'h0000_0000_1122_3344);
    load("lwu40",  F_WU, 64'd40,   64'h0000_0000_5566_7788);
    load("lhu42",  F_HU, 64'd42,   64'h0000_0000_0000_5566);
    load("ld2040", F_D,  64'd2040, 64'h0000_0000_0000_CAFE);

    // SB 0xAB at 43 with junk upper bytes; a load to the same word is held during RMW_WR
    start(1'b1, F_B, 64'd43, 64'hFFFF_FFFF_FFFF_FFAB);
    chk_strobes("sb_rd", 1'b1, 1'b0);
    chk("sb_rd.addr", bus.mem_address, 64'd5);
    chk("sb_rd.ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_write = 1'b0;
    bus.funct3    = F_D;
    bus.req_addr  = 64'd40;
    #1;
    chk_strobes("sb_wr", 1'b0, 1'b1);
    chk("sb_wr.ready", 64'(bus.req_ready), 64'd0);
    chk("sb_wr.addr", bus.mem_address, 64'd5);
    chk("sb_wr.wdata", bus.mem_write_data, 64'h1122_3344_AB66_7788);
    chk("sb_wr.valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1;
    chk_resp("sb_resp", 1'b1, 1'b0, 64'd0);
    chk("ld40_acc.ready", 64'(bus.req_ready), 64'd1);
    chk_strobes("ld40_acc", 1'b1, 1'b0);
    next();
    chk_resp("ld40_merged", 1'b1, 1'b0, 64'h1122_3344_AB66_7788);

    // Faults
    faulty("lw34_mis", 1'b0, F_W, 64'd34);
    faulty("sd41_mis", 1'b1, F_D, 64'd41);
    faulty("lh33_mis", 1'b0, F_H, 64'd33);
    faulty("ld2048_oor", 1'b0, F_D, 64'd2048);
    faulty("f111", 1'b0, F_X, 64'd96);
    faulty("store_f3_1xx", 1'b1, F_BU, 64'd40);
    load("ld40_unchanged", F_D, 64'd40, 64'h1122_3344_AB66_7788);

    // SW at 12 (upper half of word 1)
    start(1'b1, F_W, 64'd12, 64'h0000_0000_DEAD_BEEF);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1;
    chk("sw12_wr.wdata", bus.mem_write_data, 64'hDEAD_BEEF_89AB_CDEF);
    @(posedge clk); #1;
    load("ld8_sw", F_D, 64'd8, 64'hDEAD_BEEF_89AB_CDEF);

    // Reset during RMW_WR of SW 0xDEADBEEF to addr 8 aborts the write
    start(1'b1, F_W, 64'd8, 64'h0000_0000_DEAD_BEEF);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk_strobes("rst_rmw", 1'b0, 1'b0);
    chk("rst_rmw.ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rmw.valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rel.ready", 64'(bus.req_ready), 64'd1);
    chk_strobes("rst_rel", 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_rel.valid", 64'(bus.resp_valid), 64'd0);
    load("ld8_unchanged", F_D, 64'd8, 64'hDEAD_BEEF_89AB_CDEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
